// File: rtl/debouncer_pkg.sv
// Shared constants for the push-button debouncer: parameter defaults and
// the width rule for the consecutive-sample counter.
`timescale 1ns/1ps

package debouncer_pkg;

  localparam int SAMPLES_DEFAULT     = 3;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Counter must hold every value 0..samples, so it needs ceil(log2(samples+1)) bits.
  function automatic int cnt_width(input int samples);
    return $clog2(samples + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(SAMPLES_DEFAULT);

endpackage : debouncer_pkg

// File: rtl/debouncer_sync_ff.sv
// sync_ff: DEPTH-deep flip-flop chain that brings an asynchronous level into
// the clk domain. All stages clear on synchronous reset.
`timescale 1ns/1ps

module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // Next state: shift the raw input into the bottom of the chain.
  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], d};
  end

  // Chain registers, cleared while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule : sync_ff

// File: rtl/debouncer.sv
// debouncer: samples a bouncing button on each rising edge of a slow,
// asynchronous 100 Hz reference and only changes btnR after SAMPLES
// consecutive samples disagree with it. Both inputs are synchronized first.
// Optional feature macro: DEBOUNCER_PULSE_EN adds btnR_pulse, a one-clk
// strobe the cycle after btnR rises.
`timescale 1ns/1ps

module debouncer
  import debouncer_pkg::*;
#(
  parameter int SAMPLES     = SAMPLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic hundredHz,
  input  logic resetButton,
  output logic btnR
`ifdef DEBOUNCER_PULSE_EN
  ,
  output logic btnR_pulse
`endif
);

  localparam int CW = cnt_width(SAMPLES);

  logic          hz_sync_s;
  logic          btn_sync_s;

  logic          hz_prev_q;
  logic          hz_prev_d;
  logic          tick_q;
  logic          tick_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          btnR_q;
  logic          btnR_d;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_hz (
    .clk (clk),
    .rst (rst),
    .d   (hundredHz),
    .q   (hz_sync_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (resetButton),
    .q   (btn_sync_s)
  );

  // Rising-edge detect on the synchronized reference; tick is registered so it
  // appears the cycle after the 0->1 is seen.
  always_comb begin
    hz_prev_d = hz_sync_s;
    tick_d    = hz_sync_s & ~hz_prev_q;
  end

  // Debounce decision: count consecutive disagreeing samples, toggle on the SAMPLES-th.
  always_comb begin
    cnt_d  = cnt_q;
    btnR_d = btnR_q;
    if (tick_q) begin
      if (btn_sync_s != btnR_q) begin
        if (cnt_q >= CW'(SAMPLES - 1)) begin
          btnR_d = ~btnR_q;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else begin
      cnt_d  = cnt_q;
      btnR_d = btnR_q;
    end
  end

  // Edge-detect, tick, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hz_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      btnR_q    <= 1'b0;
    end else begin
      hz_prev_q <= hz_prev_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      btnR_q    <= btnR_d;
    end
  end

  assign btnR = btnR_q;

`ifdef DEBOUNCER_PULSE_EN
  logic btnR_prev_q;
  logic btnR_prev_d;
  logic pulse_q;
  logic pulse_d;

  // Rise detect on the registered output; strobe lands one clk after btnR rises.
  always_comb begin
    btnR_prev_d = btnR_q;
    pulse_d     = btnR_q & ~btnR_prev_q;
  end

  // Pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      btnR_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      btnR_prev_q <= btnR_prev_d;
      pulse_q     <= pulse_d;
    end
  end

  assign btnR_pulse = pulse_q;
`endif

endmodule : debouncer

// File: tb/tb_debouncer.sv
// Bench for debouncer: directed scenarios followed by random bouncing button
// activity, checked against a sample-queue model driven by the raw 100 Hz edges.
`timescale 1ns/1ps

module tb_debouncer;

  localparam int SAMPLES     = 3;
  localparam int SYNC_STAGES = 2;

  logic clk         = 1'b0;
  logic rst         = 1'b1;
  logic hundredHz   = 1'b0;
  logic resetButton = 1'b0;
  logic btnR;
`ifdef DEBOUNCER_PULSE_EN
  logic btnR_pulse;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  debouncer #(.SAMPLES(SAMPLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .hundredHz   (hundredHz),
    .resetButton (resetButton)
`ifdef DEBOUNCER_PULSE_EN
    ,
    .btnR        (btnR),
    .btnR_pulse  (btnR_pulse)
`else
    ,
    .btnR        (btnR)
`endif
  );

  // 1 ns system clock, posedges at x.5 ns.
  always #0.5 clk = ~clk;

  // 100 ns reference, rising edges at 50 + 100k ns.
  always #50 hundredHz = ~hundredHz;

  // Reference model: every sample taken since the last change or reset is kept;
  // the button level flips once the newest SAMPLES samples all disagree with it.
  logic samp_q[$];
  logic exp_btn = 1'b0;
  bit   all_diff;
  always @(posedge hundredHz or posedge rst) begin
    if (rst) begin
      samp_q.delete();
      exp_btn = 1'b0;
    end else begin
      samp_q.push_back(resetButton);
      if (samp_q.size() >= SAMPLES) begin
        all_diff = 1'b1;
        for (int i = samp_q.size() - SAMPLES; i < samp_q.size(); i++) begin
          if (samp_q[i] == exp_btn) all_diff = 1'b0;
        end
        if (all_diff) begin
          exp_btn = ~exp_btn;
          samp_q.delete();
        end
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $realtime);
    end
  endtask

  task automatic goto(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // Check btnR against the model 1 ns before and 9 ns after every reference edge up to t_end.
  task automatic run_until(input realtime t_end);
    realtime cp;
    bit      post;
    cp   = $floor($realtime / 100.0) * 100.0 + 49.0;
    post = 1'b0;
    while (cp <= $realtime) begin
      if (!post) begin cp = cp + 10.0; post = 1'b1; end
      else       begin cp = cp + 90.0; post = 1'b0; end
    end
    while (cp < t_end) begin
      goto(cp);
      chk(post ? "btnR_post_edge" : "btnR_pre_edge", btnR, exp_btn);
      if (!post) begin cp = cp + 10.0; post = 1'b1; end
      else       begin cp = cp + 90.0; post = 1'b0; end
    end
    goto(t_end);
  endtask

`ifdef DEBOUNCER_PULSE_EN
  // Pulse monitor: btnR_pulse must equal "btnR was high one clk ago and low two clks ago".
  logic b_m1 = 1'b0;
  logic b_m2 = 1'b0;
  int   rst_age = 0;
  always @(negedge clk) begin
    if (rst) rst_age = 0;
    else if (rst_age < 3) rst_age++;
    if (rst) chk("pulse_in_reset", btnR_pulse, 1'b0);
    else if (rst_age >= 3) chk("btnR_pulse", btnR_pulse, b_m1 & ~b_m2);
    b_m2 = b_m1;
    b_m1 = btnR;
  end
`endif

  // Directed steps, then random bouncing activity.
  initial begin
    realtime base;
    logic    b;
    int      nb;

    // Reset for 10 clks with the button held low.
    repeat (5) @(posedge clk);
    #0.2;
    chk("btnR_during_reset", btnR, 1'b0);
    repeat (5) @(posedge clk);
    #0.5;
    rst = 1'b0;
    #0.2;
    chk("btnR_after_reset", btnR, 1'b0);
    run_until(120.0);

    // One sample high (edge at 150) then back low: no change.
    resetButton = 1'b1;
    goto(230.0);
    resetButton = 1'b0;
    run_until(340.0);

    // Two samples high (edges 350, 450) then low: no change.
    resetButton = 1'b1;
    goto(465.0);
    resetButton = 1'b0;
    run_until(605.0);

    // Clean press held: samples at 650, 750, 850; btnR must be up before 860.
    resetButton = 1'b1;
    run_until(849.2);
    chk("req026_before_third", btnR, 1'b0);
    run_until(859.2);
    chk("req026_rise", btnR, 1'b1);
    run_until(920.0);

    // Release with one bounce back: 0,0,1 then 0,0,0 -> falls after 1450.
    resetButton = 1'b0;
    run_until(1120.0);
    resetButton = 1'b1;
    run_until(1220.0);
    resetButton = 1'b0;
    run_until(1449.2);
    chk("req027_hold", btnR, 1'b1);
    run_until(1459.2);
    chk("req027_fall", btnR, 1'b0);
    run_until(1520.0);

    // Two differing samples (1550, 1650), one-clk reset, then three fresh samples needed.
    resetButton = 1'b1;
    run_until(1700.0);
    rst = 1'b1;
    #1.0;
    rst = 1'b0;
    #0.2;
    chk("req028_after_reset", btnR, 1'b0);
    run_until(1759.2);
    chk("req028_no_carry", btnR, 1'b0);
    run_until(1949.2);
    chk("req028_before_third", btnR, 1'b0);
    run_until(1959.2);
    chk("req028_rise", btnR, 1'b1);
    run_until(2020.0);

    // Random levels with bounce bursts that settle well before each sample edge.
    b = 1'b1;
    for (int k = 0; k < 60; k++) begin
      base = 2020.0 + 100.0 * k;
      goto(base);
      if ($urandom_range(0, 2) == 0) b = ~b;
      nb = int'($urandom_range(0, 4));
      for (int j = 0; j < nb; j++) begin
        resetButton = ~resetButton;
        #(1.0 * $urandom_range(1, 5));
      end
      resetButton = b;
      run_until(base + 100.0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_debouncer
